// File: rtl/ck_pair_gen.sv
// ck_pair_gen: producer side of the C_k correlation path.
// Takes one candidate sequence s and streams one (a, b) operand pair for each
// shift k = 1..SEQ_WIDTH-1. Both operands are zero in the top k positions, so
// the consumer subtracts m_pad (= k) from its match count to obtain C_k.
// All outputs come straight from flops; nothing is combinational from inputs.
module ck_pair_gen #(
  parameter int SEQ_WIDTH = 8,
  parameter int K_W       = $clog2(SEQ_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SEQ_WIDTH-1:0] s_seq,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [SEQ_WIDTH-1:0] m_a,
  output logic [SEQ_WIDTH-1:0] m_b,
  output logic [K_W-1:0]       m_k,
  output logic [K_W-1:0]       m_pad,
  output logic                 m_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam logic [K_W-1:0] K_FIRST = K_W'(1);
  localparam logic [K_W-1:0] K_LAST  = K_W'(SEQ_WIDTH - 1);

  // Operand a keeps only the low N-k bits of s (the overlap region).
  function automatic logic [SEQ_WIDTH-1:0] operand_a(input logic [SEQ_WIDTH-1:0] s,
                                                     input logic [K_W-1:0]       k);
    logic [SEQ_WIDTH-1:0] ones;
    ones = '1;
    return s & (ones >> k);
  endfunction

  // Operand b is s shifted down by k; zeros fill the vacated top positions.
  function automatic logic [SEQ_WIDTH-1:0] operand_b(input logic [SEQ_WIDTH-1:0] s,
                                                     input logic [K_W-1:0]       k);
    return s >> k;
  endfunction

  state_t               state_q, state_d;
  logic [SEQ_WIDTH-1:0] seq_q, seq_d;
  logic [SEQ_WIDTH-1:0] a_q, a_d;
  logic [SEQ_WIDTH-1:0] b_q, b_d;
  logic [K_W-1:0]       k_q, k_d;
  logic [K_W-1:0]       k_inc;
  logic                 last_q, last_d;
  logic                 valid_q, valid_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;

  // k_inc wraps only when k_q == K_LAST, where it is never used.
  assign k_inc = k_q + K_FIRST;

  // Next-state and next-output decode for the IDLE/STREAM controller.
  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    last_d  = last_q;
    valid_d = valid_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (s_valid && ready_q) begin
          seq_d   = s_seq;
          k_d     = K_FIRST;
          a_d     = operand_a(s_seq, K_FIRST);
          b_d     = operand_b(s_seq, K_FIRST);
          last_d  = (K_FIRST == K_LAST);
          valid_d = 1'b1;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (valid_q && m_ready) begin
          if (last_q) begin
            // Final pair taken: clear the datapath and reopen the input.
            seq_d   = '0;
            a_d     = '0;
            b_d     = '0;
            k_d     = '0;
            last_d  = 1'b0;
            valid_d = 1'b0;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            k_d    = k_inc;
            a_d    = operand_a(seq_q, k_inc);
            b_d    = operand_b(seq_q, k_inc);
            last_d = (k_inc == K_LAST);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any sequence in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      seq_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign s_ready = ready_q;
  assign m_a     = a_q;
  assign m_b     = b_q;
  assign m_k     = k_q;
  assign m_pad   = k_q;
  assign m_last  = last_q;
  assign m_valid = valid_q;
  assign busy    = busy_q;

endmodule

// File: doc/ck_pair_gen.md
Name: ck_pair_gen

Overview:
Producer side of the C_k correlation path. It accepts one candidate binary sequence s and streams SEQ_WIDTH-1 (a, b) operand pairs, one for each shift k = 1..SEQ_WIDTH-1, into the correlation counter. Unused positions are zero-padded in both operands, so each padded position counts as a match. The block reports the pad count with every pair, and the consumer computes C_k = z - m_pad. It sits between the sequence search controller and the correlation counter.

Parameters:
- SEQ_WIDTH, default 8: sequence length N. Legal range 2..64.
- K_W, default $clog2(SEQ_WIDTH): width of the shift index and pad count.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- s_seq  in  SEQ_WIDTH  candidate sequence; bit i = s_i (1 means +1, 0 means -1).
- s_valid  in  1  s_seq is valid.
- s_ready  out  1  block can accept a sequence.
- m_a  out  SEQ_WIDTH  operand a = s AND low-(N-k) mask.
- m_b  out  SEQ_WIDTH  operand b = s logical-shift-right k.
- m_k  out  K_W  current shift k.
- m_pad  out  K_W  number of zero-padded positions; equals k.
- m_last  out  1  high on the pair with k = SEQ_WIDTH-1.
- m_valid  out  1  pair outputs are valid.
- m_ready  in  1  consumer accepts the pair.
- busy  out  1  a sequence is loaded or streaming.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - s_ready=1, m_valid=0, m_last=0, busy=0.
  - m_a=0, m_b=0, m_k=0, m_pad=0; internal sequence register = 0.
  - Reset asserted mid-stream abandons the sequence immediately. No further pairs are emitted after release.
- States: IDLE and STREAM.
- IDLE:
  - s_ready=1, m_valid=0.
  - On s_valid&&s_ready: latch s_seq, set k=1, go to STREAM.
  - Next cycle: m_valid=1, m_k=1, and operands for k=1 are presented. Latency from load to first pair is 1 cycle.
- STREAM:
  - s_ready=0, busy=1; s_valid is ignored.
  - Outputs are registered and held stable while m_valid&&!m_ready. No change of any m_* signal is permitted.
  - On m_valid&&m_ready with k<SEQ_WIDTH-1: k increments and new operands appear the next cycle, so with m_ready held high there is one pair per cycle.
  - On m_valid&&m_ready with m_last=1: go to IDLE. Next cycle m_valid=0, s_ready=1, busy=0.
  - Minimum period per sequence: SEQ_WIDTH cycles (1 load cycle plus N-1 pairs).
- Operand rules for shift k:
  - m_b[i] = s[i+k] for i < N-k; m_b[i] = 0 otherwise.
  - m_a[i] = s[i] for i < N-k; m_a[i] = 0 otherwise.
  - m_pad = m_k = k.
- m_last is high if and only if k == SEQ_WIDTH-1. For SEQ_WIDTH=2, the single pair (k=1) carries m_last=1.
- k never reaches 0 or SEQ_WIDTH while m_valid=1. No wrap-around of the k counter is permitted.
- s_ready is registered, never combinational from m_ready, so no combinational path exists from input to output.
- In the m_last acceptance cycle s_ready is still 0. A new sequence offered in that cycle is accepted one cycle later.

Test Plan:
1. N=8, s=8'hFF, m_ready=1 -> 7 pairs on consecutive cycles.
   - k=1: a=b=8'h7F. k=3: a=b=8'h1F. k=7: a=b=8'h01 with m_last=1.
   - Consumer z = 8 at every k, so z - m_pad = 7,6,...,1.
2. s=8'hAA, m_ready=1 -> pairs:
   - k=1: a=8'h2A, b=8'h55.
   - k=2: a=8'h2A, b=8'h2A.
   - k=7: a=8'h00, b=8'h01.
3. Backpressure: s=8'h5C, m_ready=0 for 5 cycles at k=2 -> m_a, m_b, m_k, m_valid unchanged for all 5 cycles. Release m_ready -> k=3 on the next cycle, and no k is skipped or duplicated.
4. Back-to-back: s_valid held high with s=8'h3C then 8'h81 -> second sequence accepted exactly 1 cycle after the m_last handshake. s_ready=0 throughout the stream. Total for both sequences = 16 cycles.
5. Reset mid-stream: assert rst_n=0 at k=4, asynchronously (between clock edges) -> m_valid=0, s_ready=1, and all outputs 0 before the next edge. After release, no stale pair is emitted.
6. N=2 build, s=2'b10 -> single pair k=1, a=2'b00, b=2'b01, m_last=1. Return to IDLE the next cycle.
